// File: rtl/distributed_arithmetic_pkg.sv
// Shared constants for the 3-tap binomial DA filter: widths, tap coefficients
// and the bit-plane lookup table builder.
package da_pkg;

  localparam int XW   = 4;
  localparam int YW   = 6;
  localparam int TAPS = 3;
  localparam int AW   = TAPS;
  localparam int LW   = 3;

  localparam int C0 = 1;
  localparam int C1 = 2;
  localparam int C2 = 1;

  typedef logic [(1 << AW)-1:0][LW-1:0] lut_rom_t;

  // Each entry is the coefficient sum of the taps whose bit is set in the address.
  function automatic lut_rom_t build_lut();
    lut_rom_t   rom;
    logic [AW-1:0] addr;
    int            sum;
    rom = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      addr = AW'(i);
      sum  = 0;
      if (addr[0]) sum = sum + C0;
      if (addr[1]) sum = sum + C1;
      if (addr[2]) sum = sum + C2;
      rom[i] = LW'(sum);
    end
    return rom;
  endfunction

endpackage

// File: rtl/distributed_arithmetic_if.sv
// Sample/result bundle between the datapath and the filter stage.
interface distributed_arithmetic_if;
  import da_pkg::*;

  logic [XW-1:0] x_in_80;
  logic [YW-1:0] y_out_80;

  modport master (output x_in_80, input y_out_80);
  modport slave  (input x_in_80, output y_out_80);
endinterface

// File: rtl/distributed_arithmetic_lut.sv
// Combinational bit-plane ROM: 3-bit tap-bit address to partial coefficient sum.
module da_lut
  import da_pkg::*;
(
  input  logic [AW-1:0] addr,
  output logic [LW-1:0] value
);

  localparam lut_rom_t ROM = build_lut();

  // ROM read; the default arm keeps the decode fully specified.
  always_comb begin
    value = {LW{1'b0}};
    case (addr)
      3'd0:    value = ROM[0];
      3'd1:    value = ROM[1];
      3'd2:    value = ROM[2];
      3'd3:    value = ROM[3];
      3'd4:    value = ROM[4];
      3'd5:    value = ROM[5];
      3'd6:    value = ROM[6];
      3'd7:    value = ROM[7];
      default: value = {LW{1'b0}};
    endcase
  end

endmodule

// File: rtl/distributed_arithmetic.sv
// Fully parallel distributed-arithmetic FIR, y = x + 2*x[-1] + x[-2],
// one 4-bit unsigned sample per clock, registered 6-bit result.
module distributed_arithmetic
  import da_pkg::*;
(
  input  logic                     clk_80,
  input  logic                     rst_80,
  distributed_arithmetic_if.slave  bus
);

  logic [XW-1:0] d1_r;
  logic [XW-1:0] d2_r;
  logic [YW-1:0] y_r;
  logic [YW-1:0] y_next_s;
  logic [LW-1:0] plane_s [XW];

  // One LUT per bit plane; address bit 0 is the newest tap.
  for (genvar b = 0; b < XW; b++) begin : g_plane
    da_lut u_lut (
      .addr  ({d2_r[b], d1_r[b], bus.x_in_80[b]}),
      .value (plane_s[b])
    );
  end

  // Shift-add of the plane partial sums; peak is 4*15 = 60, so 6 bits never wrap.
  always_comb begin
    y_next_s = {YW{1'b0}};
    for (int b = 0; b < XW; b++) begin
      y_next_s = y_next_s + (YW'(plane_s[b]) << b);
    end
  end

  // Delay line and output register; reset discards all history.
  always_ff @(posedge clk_80 or negedge rst_80) begin
    if (!rst_80) begin
      d1_r <= {XW{1'b0}};
      d2_r <= {XW{1'b0}};
      y_r  <= {YW{1'b0}};
    end else begin
      d1_r <= bus.x_in_80;
      d2_r <= d1_r;
      y_r  <= y_next_s;
    end
  end

  assign bus.y_out_80 = y_r;

endmodule

// File: tb/tb_distributed_arithmetic.sv
// Self-checking bench for distributed_arithmetic against a sample-history model.
module tb_distributed_arithmetic;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   hist[$];
  int   coef[3];

  distributed_arithmetic_if bus ();

  distributed_arithmetic dut (
    .clk_80 (clk),
    .rst_80 (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic int model_y();
    int s;
    s = 0;
    for (int k = 0; k < 3; k++) begin
      if (k < hist.size()) s += coef[k] * hist[k];
    end
    return s;
  endfunction

  // Apply one sample, advance one edge, compare against the model.
  task automatic step(input string tag, input int x);
    bus.x_in_80 = 4'(x);
    @(posedge clk);
    #1;
    hist.push_front(x);
    if (hist.size() > 3) void'(hist.pop_back());
    check(tag, int'(bus.y_out_80), model_y());
  endtask

  task automatic do_reset();
    rst = 1'b0;
    hist.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int directed_x[9];
    int directed_y[9];
    int impulse_y[4];
    int max_y[4];
    int x;

    checks   = 0;
    failures = 0;
    coef     = '{1, 2, 1};
    directed_x = '{0, 11, 5, 15, 6, 14, 6, 14, 3};
    directed_y = '{0, 11, 27, 36, 41, 41, 40, 40, 37};
    impulse_y  = '{1, 2, 1, 0};
    max_y      = '{15, 45, 60, 60};

    // Reset held with a busy input: output stays at zero.
    rst = 1'b0;
    bus.x_in_80 = 4'd15;
    #1;
    check("reset_initial", int'(bus.y_out_80), 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", int'(bus.y_out_80), 0);
    end
    rst = 1'b1;
    hist.delete();
    step("reset_release_zero", 0);

    // Impulse response.
    do_reset();
    step("impulse", 1);
    check("impulse_tab0", int'(bus.y_out_80), impulse_y[0]);
    for (int i = 1; i < 4; i++) begin
      step("impulse", 0);
      check("impulse_tab", int'(bus.y_out_80), impulse_y[i]);
    end

    // Directed stream.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step("directed", directed_x[i]);
      check("directed_tab", int'(bus.y_out_80), directed_y[i]);
    end

    // Full-scale input: no wrap at the 6-bit boundary.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step("max", 15);
      check("max_tab", int'(bus.y_out_80), max_y[i]);
    end

    // Asynchronous reset pulse between edges mid-stream.
    do_reset();
    step("async_pre", 11);
    step("async_pre", 5);
    #2;
    rst = 1'b0;
    #1;
    check("async_clear", int'(bus.y_out_80), 0);
    rst = 1'b1;
    hist.delete();
    step("async_restart", 15);
    check("async_restart_tab", int'(bus.y_out_80), 15);
    step("async_tail1", 0);
    step("async_tail2", 0);
    step("async_tail3", 0);

    // Randomized stream against the direct-form model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      x = int'($urandom_range(0, 15));
      step("random", x);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
